// File: rtl/os_mix_pkg.sv
// rtl/os_mix_pkg.sv - shared widths and forward fold/XOR mixer for the mixed-operand path
package os_mix_pkg;

  localparam int W     = 31;
  localparam int SHIFT = 16;
  localparam int L     = W - SHIFT;

  // y = z0^z1^z2 with z0's upper bits folded down and z2's lower bits folded up.
  function automatic logic [W-1:0] mix_fwd(input logic [W-1:0] z0,
                                           input logic [W-1:0] z1,
                                           input logic [W-1:0] z2);
    return z0 ^ z1 ^ z2 ^ (z0 >> SHIFT) ^ (z2 << SHIFT);
  endfunction

endpackage

// File: rtl/os_pipe_stage.sv
// rtl/os_pipe_stage.sv - generic valid/ready register slice with full-throughput backpressure
module os_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Accepting while full is allowed when the held beat leaves on the same edge.
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/os_32bit_6_recover.sv
// rtl/os_32bit_6_recover.sv - two-stage pipelined inverse of the fold/XOR mixer, recovers z0
module os_32bit_6_recover #(
  parameter int W     = os_mix_pkg::W,
  parameter int SHIFT = os_mix_pkg::SHIFT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_y,
  input  logic [W-1:0]     in_z1,
  input  logic [W-1:0]     in_z2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_z0,
  output logic [CNT_W-1:0] out_cnt
);

  if (!(SHIFT < W && W <= 2*SHIFT)) begin : g_bad_shift
    $error("os_32bit_6_recover: SHIFT must satisfy SHIFT < W <= 2*SHIFT");
  end

  logic [W-1:0]     s1_in, s1_data, s2_in;
  logic             s1_valid, s2_ready;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Upper half becomes z0's upper bits directly; lower half is the partial word p.
  assign s1_in = in_y ^ in_z1 ^ in_z2 ^ (in_z2 << SHIFT);

  // Undo the fold: lower bits below L pick up the recovered upper bits.
  assign s2_in = s1_data ^ (s1_data >> SHIFT);

  os_pipe_stage #(.DW(W)) u_stage1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (s1_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data)
  );

  os_pipe_stage #(.DW(W)) u_stage2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s2_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_z0)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;

endmodule

// File: tb/tb_os_32bit_6_recover.sv
// tb/tb_os_32bit_6_recover.sv - vector-table and scoreboard bench for os_32bit_6_recover
module tb_os_32bit_6_recover;
  import os_mix_pkg::*;

  localparam int CNT_W = 16;
  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t y;
    word_t z1;
    word_t z2;
    word_t exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  word_t            in_y, in_z1, in_z2;
  logic             out_valid;
  logic             out_ready;
  word_t            out_z0;
  logic [CNT_W-1:0] out_cnt;

  word_t            exp_in;
  word_t            sb_q[$];
  logic [CNT_W-1:0] cnt_model;
  logic             prev_stall;
  word_t            prev_z0;
  int               rdy_mode;
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_err = 0;
  vec_t             vt[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  os_32bit_6_recover #(.W(W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_z1     (in_z1),
    .in_z2     (in_z2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z0    (out_z0),
    .out_cnt   (out_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      cnt_model = '0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(sb_q.size() == 2 && !out_ready));
      check("out_cnt_model", out_cnt, cnt_model);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_z0", out_z0, prev_z0);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          check("out_z0", out_z0, sb_q.pop_front());
          cnt_model = cnt_model + 1'b1;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_in);
      prev_stall = out_valid && !out_ready;
      prev_z0 = out_z0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) >= 3);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input word_t y, input word_t z1, input word_t z2, input word_t exp);
    bit hs;
    hs = 1'b0;
    in_valid = 1'b1;
    in_y = y;
    in_z1 = z1;
    in_z2 = z2;
    exp_in = exp;
    for (int k = 0; k < 1000 && !hs; k++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) check("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    word_t z0, z1, z2;
    z0 = word_t'($urandom());
    z1 = word_t'($urandom());
    z2 = word_t'($urandom());
    send(mix_fwd(z0, z1, z2), z1, z2, z0);
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && sb_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", sb_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_y = '1;
    in_z1 = '1;
    in_z2 = '1;
    exp_in = '0;
    rdy_mode = 0;

    vt[0] = '{y: 31'h0001_0000, z1: '0, z2: '0,            exp: 31'h0001_0001};
    vt[1] = '{y: 31'h0001_0001, z1: '0, z2: 31'h0000_0001, exp: 31'h0000_0000};
    vt[2] = '{y: 31'h0000_8000, z1: '0, z2: '0,            exp: 31'h0000_8000};
    vt[3] = '{y: mix_fwd('1, '0, '0), z1: '0, z2: '0, exp: '1};
    vt[4] = '{y: mix_fwd(31'h7FFF_8000, 31'h1234_5678, 31'h0000_7FFF), z1: 31'h1234_5678,
              z2: 31'h0000_7FFF, exp: 31'h7FFF_8000};
    vt[5] = '{y: mix_fwd(31'h2AAA_AAAA, '1, 31'h5555_5555), z1: '1, z2: 31'h5555_5555,
              exp: 31'h2AAA_AAAA};
    vt[6] = '{y: mix_fwd(31'h4000_0001, '0, 31'h4000_7FFF), z1: '0, z2: 31'h4000_7FFF,
              exp: 31'h4000_0001};
    vt[7] = '{y: mix_fwd('0, 31'h0F0F_0F0F, '1), z1: 31'h0F0F_0F0F, z2: '1, exp: '0};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_cnt", out_cnt, 0);
      check("rst_out_z0", out_z0, 0);
    end
    sync();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Exact two-cycle latency of a single beat.
    sync();
    in_valid = 1'b1;
    in_y = vt[0].y;
    in_z1 = vt[0].z1;
    in_z2 = vt[0].z2;
    exp_in = vt[0].exp;
    sync();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1_valid", out_valid, 0);
    @(negedge clk);
    check("lat2_valid", out_valid, 1);
    check("lat2_z0", out_z0, 31'h0001_0001);
    @(negedge clk);
    check("single_cnt", out_cnt, 1);

    sync();
    for (int i = 0; i < 8; i++) send(vt[i].y, vt[i].z1, vt[i].z2, vt[i].exp);
    drain();

    do_reset();
    c0 = cyc;
    for (int i = 0; i < 1000; i++) send_rand();
    check("stream_cycles", cyc - c0, 1000);
    drain();
    check("stream_cnt", out_cnt, 1000);

    sync();
    rdy_mode = 1;
    for (int i = 0; i < 1500; i++) send_rand();
    rdy_mode = 0;
    drain();

    do_reset();
    for (int i = 0; i < 65537; i++) send_rand();
    drain();
    check("wrap_cnt", out_cnt, 1);

    // Fill both stages under stall, then reset mid-flight.
    sync();
    rdy_mode = 2;
    sync();
    send_rand();
    send_rand();
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_cnt", out_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
